reg_file_ctrl: RTL and testbench
================================

REG_FILE_CTRL -- requirements
Module: reg_file_ctrl

Interface
REQ-001 SHALL use one clock and an asynchronous, active-low reset. The clock port SHALL be CLK and the reset port SHALL be RST.
REQ-002 CLK  in  1  rising-edge clock.
REQ-003 RST  in  1  async active-low reset.
REQ-004 cmd_valid  in  1  command offered.
REQ-005 cmd_ready  out  1  controller can accept a command.
REQ-006 cmd_op  in  1  0 = read, 1 = write.
REQ-007 cmd_addr  in  3  target register index.
REQ-008 cmd_wdata  in  16  write data.
REQ-009 rsp_valid  out  1  read response available.
REQ-010 rsp_ready  in  1  response consumer ready.
REQ-011 rsp_rdata  out  16  read data returned.
REQ-012 rsp_addr  out  3  address the response belongs to.
REQ-013 rf_WrEn / rf_RdEn  out  1 each  register-file strobes.
REQ-014 rf_Address  out  3  register-file address.
REQ-015 rf_WrData  out  16  register-file write data.
REQ-016 rf_RdData  in  16  register-file read data, registered inside the register file with 1-cycle latency.
REQ-017 wr_cnt / rd_cnt  out  8 each  completed write and read transaction counts.

Function
REQ-018 SHALL implement FSM states IDLE, WRITE, READ, CAPTURE, RESP; all outputs SHALL be registered.
REQ-019 IDLE: cmd_ready=1; on cmd_valid&&cmd_ready at an edge, latch op/addr/wdata, drop cmd_ready, go to WRITE (op=1) or READ (op=0).
REQ-020 WRITE: rf_WrEn=1 for exactly one cycle, with rf_Address/rf_WrData = latched values; then IDLE, cmd_ready=1 next cycle.
REQ-021 READ: rf_RdEn=1 for exactly one cycle with rf_Address = latched addr; then CAPTURE.
REQ-022 CAPTURE: sample rf_RdData into rsp_rdata, set rsp_addr, assert rsp_valid; go to RESP.
REQ-023 RESP: hold rsp_valid/rsp_rdata/rsp_addr stable until rsp_valid&&rsp_ready at an edge; then clear rsp_valid, go to IDLE.
REQ-024 Latency: a read accepted at edge N SHALL assert rsp_valid from edge N+3; a write accepted at edge N SHALL pulse rf_WrEn during cycle N..N+1.
REQ-025 rf_WrEn and rf_RdEn SHALL never be high in the same cycle.
REQ-026 cmd_ready SHALL be 0 in every state except IDLE; commands offered while busy SHALL be held off, never dropped.
REQ-027 rf_Address/rf_WrData SHALL keep their last value when no strobe is active.
REQ-028 wr_cnt SHALL increment in the WRITE cycle and rd_cnt on the response handshake; both SHALL saturate at 255 with no wrap.
REQ-029 rsp_ready high outside RESP SHALL have no effect.

Reset
REQ-030 On RST=0, all state SHALL clear asynchronously: state=IDLE; cmd_ready, rsp_valid, rf_WrEn, rf_RdEn = 0; rsp_rdata, rsp_addr, rf_Address, rf_WrData, wr_cnt, rd_cnt = 0.
REQ-031 cmd_ready SHALL rise on the first CLK edge after RST deasserts.
REQ-032 Reset mid-transaction SHALL abort it: a pending response is discarded, strobes drop immediately, and counters do not count the aborted transaction.

Structure
REQ-033 Data width (16), address width (3), opcode constants and the FSM state enum SHALL live in a shared package used by reg_file_ctrl and the register-file top.
REQ-034 No sub-module is required; the register file is a sibling instance connected at the level above.

Verification
REQ-035 Write 0xA5A5 to addr 3, then read addr 3 -> one rf_WrEn pulse with addr 3; rsp_valid 3 edges after read accept; rsp_rdata=0xA5A5, rsp_addr=3; wr_cnt=1, rd_cnt=1.
REQ-036 Write all 8 addresses with value 0x1000+addr, then read back each -> every response matches; rf_WrEn and rf_RdEn never overlap.
REQ-037 rsp_ready held low for 5 cycles during a read of addr 7 -> rsp_valid and rsp_rdata held stable, cmd_ready stays 0, the held-off command is accepted only after the handshake.
REQ-038 cmd_valid held continuously with back-to-back writes -> one accept every 2 cycles; wr_cnt reaches 255 after 255 writes and stays 255 after 300.
REQ-039 RST asserted in the CAPTURE state of a read -> all outputs 0 immediately; no response after release; cmd_ready=1 one edge after release.

Source files
------------

// File: rtl/reg_file_ctrl_pkg.sv
// Shared widths, opcodes and controller state encoding for the register-file slice.
package reg_file_ctrl_pkg;

   localparam int DW = 16;
   localparam int AW = 3;
   localparam int CW = 8;

   localparam logic       OP_READ  = 1'b0;
   localparam logic       OP_WRITE = 1'b1;
   localparam logic [CW-1:0] CNT_MAX = '1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_READ,
      ST_CAPTURE,
      ST_RESP
   } state_t;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/reg_file_ctrl.sv
// Command/response front end for a sibling register file: one transaction at a time.
// Read: accept at N, rf_RdEn N..N+1, rsp_valid from N+3. Write: rf_WrEn N..N+1. Busy => cmd_ready low.
module reg_file_ctrl
   import reg_file_ctrl_pkg::*;
(
   input  logic          CLK,
   input  logic          RST,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_op,
   input  logic [AW-1:0] cmd_addr,
   input  logic [DW-1:0] cmd_wdata,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_rdata,
   output logic [AW-1:0] rsp_addr,
   output logic          rf_WrEn,
   output logic          rf_RdEn,
   output logic [AW-1:0] rf_Address,
   output logic [DW-1:0] rf_WrData,
   input  logic [DW-1:0] rf_RdData,
   output logic [CW-1:0] wr_cnt,
   output logic [CW-1:0] rd_cnt
);

   state_t        state_q;
   logic          cmd_ready_q;
   logic          rsp_valid_q;
   logic [DW-1:0] rsp_rdata_q;
   logic [AW-1:0] rsp_addr_q;
   logic          rf_wren_q;
   logic          rf_rden_q;
   logic [AW-1:0] rf_addr_q;
   logic [DW-1:0] rf_wdata_q;
   logic [CW-1:0] wr_cnt_q;
   logic [CW-1:0] rd_cnt_q;
   logic [DW-1:0] rdata_in_q;
   logic          cap_wait_q;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q     <= ST_IDLE;
         cmd_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_addr_q  <= '0;
         rf_wren_q   <= 1'b0;
         rf_rden_q   <= 1'b0;
         rf_addr_q   <= '0;
         rf_wdata_q  <= '0;
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         rdata_in_q  <= '0;
         cap_wait_q  <= 1'b0;
      end else begin
         // Read data crosses the hierarchy boundary through this flop before use.
         rdata_in_q <= rf_RdData;
         case (state_q)
            ST_IDLE: begin
               if (cmd_valid && cmd_ready_q) begin
                  cmd_ready_q <= 1'b0;
                  rf_addr_q   <= cmd_addr;
                  if (cmd_op == OP_WRITE) begin
                     rf_wren_q  <= 1'b1;
                     rf_wdata_q <= cmd_wdata;
                     state_q    <= ST_WRITE;
                  end else begin
                     rf_rden_q  <= 1'b1;
                     state_q    <= ST_READ;
                  end
               end else begin
                  cmd_ready_q <= 1'b1;
               end
            end
            ST_WRITE: begin
               rf_wren_q   <= 1'b0;
               wr_cnt_q    <= sat_inc(wr_cnt_q);
               cmd_ready_q <= 1'b1;
               state_q     <= ST_IDLE;
            end
            ST_READ: begin
               rf_rden_q  <= 1'b0;
               cap_wait_q <= 1'b1;
               state_q    <= ST_CAPTURE;
            end
            ST_CAPTURE: begin
               if (cap_wait_q) begin
                  cap_wait_q <= 1'b0;
               end else begin
                  rsp_rdata_q <= rdata_in_q;
                  rsp_addr_q  <= rf_addr_q;
                  rsp_valid_q <= 1'b1;
                  state_q     <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  rd_cnt_q    <= sat_inc(rd_cnt_q);
                  cmd_ready_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign cmd_ready  = cmd_ready_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_rdata  = rsp_rdata_q;
   assign rsp_addr   = rsp_addr_q;
   assign rf_WrEn    = rf_wren_q;
   assign rf_RdEn    = rf_rden_q;
   assign rf_Address = rf_addr_q;
   assign rf_WrData  = rf_wdata_q;
   assign wr_cnt     = wr_cnt_q;
   assign rd_cnt     = rd_cnt_q;

endmodule

// File: tb/tb_reg_file_ctrl.sv
// Directed + randomized bench for reg_file_ctrl with a behavioural register file and reference model.
module tb_reg_file_ctrl;
   import reg_file_ctrl_pkg::*;

   logic          CLK = 1'b0;
   logic          RST;
   logic          cmd_valid, cmd_ready, cmd_op;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid, rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic [AW-1:0] rsp_addr;
   logic          rf_WrEn, rf_RdEn;
   logic [AW-1:0] rf_Address;
   logic [DW-1:0] rf_WrData;
   logic [DW-1:0] rf_RdData = '0;
   logic [CW-1:0] wr_cnt, rd_cnt;

   reg_file_ctrl dut (
      .CLK(CLK), .RST(RST),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_addr(rsp_addr),
      .rf_WrEn(rf_WrEn), .rf_RdEn(rf_RdEn),
      .rf_Address(rf_Address), .rf_WrData(rf_WrData), .rf_RdData(rf_RdData),
      .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc++;

   // Sibling register file: synchronous write, registered read data.
   logic [DW-1:0] rf_mem [8];
   always @(posedge CLK) begin
      if (rf_WrEn) rf_mem[rf_Address] <= rf_WrData;
      if (rf_RdEn) rf_RdData <= rf_mem[rf_Address];
   end

   int overlap = 0;
   always @(negedge CLK) if (rf_WrEn && rf_RdEn) overlap++;

   // Reference model: expected register contents and transaction counts.
   logic [DW-1:0] ref_mem [8];
   int            exp_wr = 0, exp_rd = 0;
   logic [DW-1:0] last_wd = '0;

   int n_chk = 0, n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_ctl"}, 64'({cmd_ready, rsp_valid, rf_WrEn, rf_RdEn}), 64'd0);
      chk({tag, "_dat"}, 64'({rsp_rdata, rsp_addr, rf_Address, rf_WrData}), 64'd0);
      chk({tag, "_cnt"}, 64'({wr_cnt, rd_cnt}), 64'd0);
   endtask

   // Called at a negedge; returns at the negedge just after the accepting edge.
   task automatic offer(input logic op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int waited);
      logic rdy;
      bit   done = 0;
      cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = d;
      waited = 0;
      while (!done && waited < 60) begin
         rdy = cmd_ready;
         @(posedge CLK);
         if (rdy) done = 1;
         else waited++;
         @(negedge CLK);
      end
      cmd_valid = 1'b0;
      if (!done) chk("accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, output int waited);
      offer(OP_WRITE, a, d, waited);
      chk("wr_strobe", 64'({rf_WrEn, rf_RdEn, cmd_ready, rf_Address, rf_WrData}),
          64'({1'b1, 1'b0, 1'b0, a, d}));
      ref_mem[a] = d;
      last_wd    = d;
      exp_wr     = (exp_wr < 255) ? exp_wr + 1 : 255;
      @(negedge CLK);
      chk("wr_done", 64'({rf_WrEn, cmd_ready, wr_cnt}), 64'({1'b0, 1'b1, 8'(exp_wr)}));
   endtask

   task automatic do_read(input logic [AW-1:0] a, input int hold, input logic early, input bit pend);
      int            w;
      logic [DW-1:0] exp_d;
      rsp_ready = early;
      offer(OP_READ, a, '0, w);
      exp_d = ref_mem[a];
      chk("rd_strobe", 64'({rf_RdEn, rf_WrEn, rf_Address, rf_WrData}),
          64'({1'b1, 1'b0, a, last_wd}));
      @(negedge CLK);
      chk("rd_n1", 64'({rf_RdEn, rsp_valid}), 64'd0);
      @(negedge CLK);
      chk("rd_n2", 64'(rsp_valid), 64'd0);
      @(negedge CLK);
      chk("rd_n3", 64'({rsp_valid, cmd_ready, rsp_addr, rsp_rdata}),
          64'({1'b1, 1'b0, a, exp_d}));
      rsp_ready = 1'b0;
      if (pend) begin
         cmd_valid = 1'b1; cmd_op = OP_WRITE; cmd_addr = '0; cmd_wdata = 16'hBEEF;
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge CLK);
         chk("rsp_hold", 64'({rsp_valid, cmd_ready, rf_WrEn, rsp_addr, rsp_rdata}),
             64'({1'b1, 1'b0, 1'b0, a, exp_d}));
      end
      rsp_ready = 1'b1;
      @(negedge CLK);
      rsp_ready = 1'b0;
      exp_rd = (exp_rd < 255) ? exp_rd + 1 : 255;
      chk("rsp_done", 64'({rsp_valid, cmd_ready, rf_WrEn, rd_cnt}),
          64'({1'b0, 1'b1, 1'b0, 8'(exp_rd)}));
   endtask

   initial begin
      int   w, npulse, last, bad, seen;
      logic op;
      logic [AW-1:0] a;

      RST = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
      #12;
      check_zero("reset_state");
      @(negedge CLK); RST = 1'b1;
      chk("rdy_before_edge", 64'(cmd_ready), 64'd0);
      @(negedge CLK);
      chk("rdy_first_edge", 64'(cmd_ready), 64'd1);

      // Single write then read-back.
      do_write(3'd3, 16'hA5A5, w);
      do_read(3'd3, 0, 1'b0, 0);
      chk("basic_cnt", 64'({wr_cnt, rd_cnt}), 64'(16'h0101));

      // Fill every address, read all back.
      for (int i = 0; i < 8; i++) do_write(3'(i), 16'(16'h1000 + i), w);
      for (int i = 0; i < 8; i++) do_read(3'(i), 1, 1'b0, 0);

      // Randomized mix; early rsp_ready exercises "ready outside RESP is ignored".
      for (int i = 0; i < 30; i++) begin
         op = 1'($urandom_range(0, 1));
         a  = 3'($urandom_range(0, 7));
         if (op) do_write(a, 16'($urandom), w);
         else    do_read(a, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0);
      end

      // Long back-pressure on a read of addr 7 with a write waiting behind it.
      do_write(3'd7, 16'h7E57, w);
      do_read(3'd7, 5, 1'b0, 1);
      do_write(3'd0, 16'hBEEF, w);
      chk("held_cmd_accept_wait", 64'(w), 64'd0);

      // Back-to-back writes with cmd_valid held: spacing and counter saturation.
      @(negedge CLK); RST = 1'b0;
      #1; check_zero("reset2");
      @(negedge CLK); RST = 1'b1;
      exp_wr = 0; exp_rd = 0; last_wd = '0;
      cmd_valid = 1'b1; cmd_op = OP_WRITE; cmd_addr = 3'd5; cmd_wdata = 16'h5555;
      npulse = 0; last = 0; bad = 0;
      for (int i = 0; i < 700 && npulse < 300; i++) begin
         @(negedge CLK);
         if (rf_WrEn) begin
            npulse++;
            if (npulse > 1 && cyc - last != 2) bad++;
            last = cyc;
            if (npulse == 255) chk("wr_cnt_254", 64'(wr_cnt), 64'd254);
            if (npulse == 256) chk("wr_cnt_255", 64'(wr_cnt), 64'd255);
         end
      end
      cmd_valid = 1'b0;
      chk("b2b_pulses", 64'(npulse), 64'd300);
      chk("b2b_spacing_bad", 64'(bad), 64'd0);
      @(negedge CLK);
      chk("wr_cnt_sat", 64'({wr_cnt, rd_cnt, cmd_ready}), 64'({8'd255, 8'd0, 1'b1}));
      ref_mem[5] = 16'h5555; last_wd = 16'h5555; exp_wr = 255;

      // Reset while a read sits in CAPTURE.
      offer(OP_READ, 3'd2, '0, w);
      chk("abort_rd_strobe", 64'(rf_RdEn), 64'd1);
      @(negedge CLK);
      RST = 1'b0;
      #1; check_zero("abort");
      @(negedge CLK); RST = 1'b1;
      chk("abort_rdy_before_edge", 64'(cmd_ready), 64'd0);
      @(negedge CLK);
      chk("abort_rdy_first_edge", 64'(cmd_ready), 64'd1);
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         if (rsp_valid || rf_RdEn) seen++;
      end
      chk("abort_no_rsp", 64'({seen[7:0], rd_cnt, wr_cnt}), 64'd0);

      chk("strobe_overlap", 64'(overlap), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
